gcd_sched: RTL and testbench

- Sequential controller and round-robin scheduler that shares one subtract-based GCD engine between NREQ requesters.
- Arbitrates incoming operand pairs and loads the engine registers.
- Steps the engine one subtraction per clock until a termination condition, then returns the result with the requester ID over a valid/ready response port.
- Sits between the operand sources and the result consumer, replacing free-running combinational iteration with a clocked, handshaked unit.

---
 rtl/gcd_sched_pkg.sv | 13 +
 rtl/gcd_step_dp.sv | 54 +++++
 rtl/gcd_sched.sv | 149 ++++++++++++++
 tb/tb_gcd_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_sched_pkg.sv
// Shared types and defaults for the gcd_sched controller and its datapath.
package gcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

endpackage

// File: rtl/gcd_step_dp.sv
// Operand registers of the shared subtract-based GCD engine: load, one subtraction per step,
// plus the zero and magnitude status the controller steers from.
module gcd_step_dp
  import gcd_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             sub_a,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic [WIDTH-1:0] areg,
  output logic [WIDTH-1:0] breg,
  output logic             a_zero,
  output logic             b_zero,
  output logic             a_gt_b
);

  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;

  // The controller only steps with both operands non-zero, so the larger one is always the minuend.
  always_comb begin
    areg_d = areg_q;
    breg_d = breg_q;
    if (load) begin
      areg_d = load_a;
      breg_d = load_b;
    end else if (step) begin
      if (sub_a) areg_d = areg_q - breg_q;
      else       breg_d = breg_q - areg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      areg_q <= '0;
      breg_q <= '0;
    end else begin
      areg_q <= areg_d;
      breg_q <= breg_d;
    end
  end

  assign areg   = areg_q;
  assign breg   = breg_q;
  assign a_zero = (areg_q == '0);
  assign b_zero = (breg_q == '0);
  assign a_gt_b = (areg_q > breg_q);

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one clocked GCD engine between NREQ requesters,
// returning each result with its owner's ID over a valid/ready port.
module gcd_sched
  import gcd_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_gcd,
  output logic                  busy
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_gcd_q, resp_gcd_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic [IDW:0]     idx_w;
  logic [IDW:0]     nxt_w;

  logic             load, step;
  logic [WIDTH-1:0] areg, breg;
  logic             a_zero, b_zero, a_gt_b;

  // Search from the pointer upward with wrap; nothing is offered outside IDLE or while in reset.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx_w   = '0;
    if (state_q == IDLE && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
        if (idx_w >= NREQ_W) idx_w = idx_w - NREQ_W;
        if (!gnt_any && req_valid[idx_w[IDW-1:0]]) begin
          grant[idx_w[IDW-1:0]] = 1'b1;
          gnt_id                = idx_w[IDW-1:0];
          gnt_any               = 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt_w = {1'b0, gnt_id} + (IDW+1)'(1);
    if (nxt_w >= NREQ_W) nxt_w = nxt_w - NREQ_W;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_id_d   = cur_id_q;
    resp_id_d  = resp_id_q;
    resp_gcd_d = resp_gcd_q;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          load     = 1'b1;
          cur_id_d = gnt_id;
          ptr_d    = nxt_w[IDW-1:0];
          state_d  = RUN;
        end
      end
      RUN: begin
        if (a_zero) begin
          resp_gcd_d = breg;
          resp_id_d  = cur_id_q;
          state_d    = DONE;
        end else if (b_zero) begin
          resp_gcd_d = areg;
          resp_id_d  = cur_id_q;
          state_d    = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cur_id_q     <= '0;
      resp_id_q    <= '0;
      resp_gcd_q   <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cur_id_q     <= cur_id_d;
      resp_id_q    <= resp_id_d;
      resp_gcd_q   <= resp_gcd_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  gcd_step_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .sub_a  (a_gt_b),
    .load_a (req_a[int'(gnt_id)*WIDTH +: WIDTH]),
    .load_b (req_b[int'(gnt_id)*WIDTH +: WIDTH]),
    .areg   (areg),
    .breg   (breg),
    .a_zero (a_zero),
    .b_zero (b_zero),
    .a_gt_b (a_gt_b)
  );

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_gcd   = resp_gcd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched: scenario tasks compared against a Euclid/step-count reference model.
module tb_gcd_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid, resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_gcd;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_gcd   (resp_gcd),
    .busy       (busy)
  );

  // Reference model: Euclid by remainder for the value, counted subtractions for the latency.
  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int lat_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    while (a != 0 && b != 0) begin
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
    return n + 1;
  endfunction

  task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Offers one request, waits for the grant and the response; returns what it saw, compares nothing.
  task automatic run_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output logic [WIDTH-1:0] g, output logic [IDW-1:0] rid,
                         output bit ok);
    int waited;
    ok = 1'b0; lat = 0; g = '0; rid = '0;
    set_req(id, a, b);
    req_valid[id] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[id] && waited < 50) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    while (!resp_valid && lat < 700) begin
      @(posedge clk); #1;
      lat++;
    end
    ok  = resp_valid;
    g   = resp_gcd;
    rid = resp_id;
  endtask

  task automatic test_reset();
    resp_ready = 1'b1;
    req_a = '0; req_b = '0;
    do_reset();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (resp_gcd !== 8'd0) begin failures++; $display("[TB] FAIL reset_resp_gcd got=%0d want=0", resp_gcd); end
    checks++; if (resp_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_id got=%0d want=0", resp_id); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready_idle got=%b want=00", req_ready); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL reset_ptr_grant got=%b want=01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_basic();
    int lat; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; bit ok;
    resp_ready = 1'b1;
    run_req(0, 8'd12, 8'd8, lat, g, rid, ok);
    checks++; if (!ok || lat != lat_ref(8'd12, 8'd8)) begin failures++; $display("[TB] FAIL basic_latency got=%0d ok=%0d want=%0d", lat, ok, lat_ref(8'd12, 8'd8)); end
    checks++; if (g !== gcd_ref(8'd12, 8'd8)) begin failures++; $display("[TB] FAIL basic_gcd got=%0d want=%0d", g, gcd_ref(8'd12, 8'd8)); end
    checks++; if (rid !== 1'b0) begin failures++; $display("[TB] FAIL basic_id got=%0d want=0", rid); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_after_hs busy=%b valid=%b want=0/0", busy, resp_valid); end
  endtask

  task automatic test_zero_equal();
    logic [WIDTH-1:0] ta[4] = '{8'd0, 8'd0, 8'd7, 8'd5};
    logic [WIDTH-1:0] tb[4] = '{8'd0, 8'd9, 8'd0, 8'd5};
    int lat; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; bit ok;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_req(i % 2, ta[i], tb[i], lat, g, rid, ok);
      checks++; if (!ok || lat != lat_ref(ta[i], tb[i])) begin failures++; $display("[TB] FAIL zero_eq_latency case=%0d got=%0d want=%0d", i, lat, lat_ref(ta[i], tb[i])); end
      checks++; if (g !== gcd_ref(ta[i], tb[i])) begin failures++; $display("[TB] FAIL zero_eq_gcd case=%0d got=%0d want=%0d", i, g, gcd_ref(ta[i], tb[i])); end
      checks++; if (rid !== IDW'(i % 2)) begin failures++; $display("[TB] FAIL zero_eq_id case=%0d got=%0d want=%0d", i, rid, i % 2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] ma[2] = '{8'd54, 8'd17};
    logic [WIDTH-1:0] mb[2] = '{8'd24, 8'd5};
    int ptr_m = 0;
    int lat;
    logic [NREQ-1:0] exp_gnt;
    do_reset();
    resp_ready = 1'b1;
    set_req(0, ma[0], mb[0]);
    set_req(1, ma[1], mb[1]);
    req_valid = 2'b11;
    for (int r = 0; r < 3; r++) begin
      exp_gnt = '0;
      exp_gnt[ptr_m] = 1'b1;
      #1;
      checks++; if (req_ready !== exp_gnt) begin failures++; $display("[TB] FAIL contention_grant round=%0d got=%b want=%b", r, req_ready, exp_gnt); end
      @(posedge clk); #1;
      lat = 0;
      while (!resp_valid && lat < 700) begin @(posedge clk); #1; lat++; end
      checks++; if (resp_valid !== 1'b1 || resp_id !== IDW'(ptr_m)) begin failures++; $display("[TB] FAIL contention_id round=%0d got=%0d want=%0d", r, resp_id, ptr_m); end
      checks++; if (resp_gcd !== gcd_ref(ma[ptr_m], mb[ptr_m])) begin failures++; $display("[TB] FAIL contention_gcd round=%0d got=%0d want=%0d", r, resp_gcd, gcd_ref(ma[ptr_m], mb[ptr_m])); end
      ptr_m = (ptr_m + 1) % NREQ;
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    while (busy) begin @(posedge clk); #1; end
  endtask

  task automatic test_backpressure();
    int lat; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; bit ok;
    logic [WIDTH-1:0] a, b;
    a = WIDTH'($urandom_range(1, 60));
    b = WIDTH'($urandom_range(1, 60));
    resp_ready = 1'b0;
    run_req(1, a, b, lat, g, rid, ok);
    checks++; if (!ok || g !== gcd_ref(a, b)) begin failures++; $display("[TB] FAIL bp_gcd got=%0d ok=%0d want=%0d", g, ok, gcd_ref(a, b)); end
    set_req(0, 8'd30, 8'd20);
    req_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_gcd !== gcd_ref(a, b) || resp_id !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold cycle=%0d valid=%b gcd=%0d id=%0d want=1/%0d/1", c, resp_valid, resp_gcd, resp_id, gcd_ref(a, b)); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL bp_ready cycle=%0d got=%b want=00", c, req_ready); end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_release valid=%b busy=%b want=0/0", resp_valid, busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; bit ok;
    int spurious = 0;
    resp_ready = 1'b1;
    set_req(0, 8'd255, 8'd1);
    req_valid[0] = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL mid_grant got=%b want=01", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (resp_valid) spurious++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_rst busy=%b valid=%b want=0/0", busy, resp_valid); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL mid_ptr got=%b want=01", req_ready); end
    req_valid = 2'b00;
    for (int c = 0; c < 250; c++) begin
      @(posedge clk); #1;
      if (resp_valid) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("[TB] FAIL mid_no_resp got=%0d want=0", spurious); end
    run_req(1, 8'd9, 8'd6, lat, g, rid, ok);
    checks++; if (!ok || g !== 8'd3 || rid !== 1'b1) begin failures++; $display("[TB] FAIL mid_fresh gcd=%0d id=%0d ok=%0d want=3/1/1", g, rid, ok); end
    @(posedge clk); #1;
  endtask

  task automatic test_worst();
    int lat = 0;
    int bad = 0;
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 8'd255, 8'd1);
    set_req(1, WIDTH'($urandom_range(1, 255)), WIDTH'($urandom_range(1, 255)));
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL worst_grant got=%b want=01", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    while (!resp_valid && lat < 700) begin
      @(posedge clk); #1;
      lat++;
      if (req_ready[1] !== 1'b0) bad++;
    end
    req_valid[1] = 1'b0;
    checks++; if (!resp_valid || lat != lat_ref(8'd255, 8'd1)) begin failures++; $display("[TB] FAIL worst_latency got=%0d want=%0d", lat, lat_ref(8'd255, 8'd1)); end
    checks++; if (resp_gcd !== 8'd1 || resp_id !== 1'b0) begin failures++; $display("[TB] FAIL worst_result gcd=%0d id=%0d want=1/0", resp_gcd, resp_id); end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL worst_other_ready got=%0d want=0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; bit ok;
    logic [WIDTH-1:0] a, b;
    int id;
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id = int'($urandom_range(0, NREQ - 1));
      a  = WIDTH'($urandom_range(0, 255));
      b  = WIDTH'($urandom_range(0, 255));
      run_req(id, a, b, lat, g, rid, ok);
      checks++; if (!ok || lat != lat_ref(a, b) || g !== gcd_ref(a, b) || rid !== IDW'(id)) begin
        failures++;
        $display("[TB] FAIL random a=%0d b=%0d got gcd=%0d lat=%0d id=%0d want gcd=%0d lat=%0d id=%0d",
                 a, b, g, lat, rid, gcd_ref(a, b), lat_ref(a, b), id);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_equal();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_worst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
